// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the fetch stage.
// Owns the PC and walks it from a start address (branch table entry 0) to HALT_ADDR,
// with stall, table-driven taken branches and a Start/Done handshake. An 8-entry
// (2**SEL_W) branch-target table is reprogrammable only while idle or done.
//
// Optional feature: define PC_SEQ_LINK_EN to add a link register with link_i/ret_i.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   reset_i        synchronous active-high reset
//   start_i        level: high arms/holds at start address, release begins the run
//   stall_i        hold PC this cycle
//   branch_en_i    current instruction is a branch
//   taken_i        branch condition true
//   target_sel_i   table index of the branch target
//   cfg_we_i       table write enable
//   cfg_addr_i     table write index
//   cfg_data_i     table write data
//   link_i         (PC_SEQ_LINK_EN) taken branch also saves PC+1 to the link register
//   ret_i          (PC_SEQ_LINK_EN) jump to the link register
//   prog_ctr_o     current PC
//   running_o      high while running
//   done_o         high after reaching HALT_ADDR
//   cfg_err_o      one-cycle pulse when a table write is refused
module pc_sequencer #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned HALT_ADDR = 1023
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic             taken_i,
  input  logic [SEL_W-1:0] target_sel_i,
  input  logic             cfg_we_i,
  input  logic [SEL_W-1:0] cfg_addr_i,
  input  logic [PC_W-1:0]  cfg_data_i,
`ifdef PC_SEQ_LINK_EN
  input  logic             link_i,
  input  logic             ret_i,
`endif
  output logic [PC_W-1:0]  prog_ctr_o,
  output logic             running_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  localparam int unsigned Depth = 2 ** SEL_W;
  localparam logic [PC_W-1:0] HaltPc = PC_W'(HALT_ADDR);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            running_q;
  logic            done_q;
  logic            cfg_err_q;
  logic [PC_W-1:0] table_q [Depth];
`ifdef PC_SEQ_LINK_EN
  logic [PC_W-1:0] link_q;
`endif

  // Power-on branch-target table contents; entries past the first eight clear to 0.
  function automatic logic [PC_W-1:0] reset_entry(int unsigned idx);
    case (idx)
      1:       return PC_W'(36);
      2:       return PC_W'(40);
      3:       return PC_W'(63);
      4:       return PC_W'(68);
      5:       return PC_W'(208);
      7:       return PC_W'(1023);
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        table_q[i] <= reset_entry(i);
      end
`ifdef PC_SEQ_LINK_EN
      link_q    <= '0;
`endif
    end else begin
      // Table port: writes land only when no run is armed or active.
      cfg_err_q <= 1'b0;
      if (cfg_we_i) begin
        if (state_q == StIdle || state_q == StDone) begin
          table_q[cfg_addr_i] <= cfg_data_i;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end

      case (state_q)
        StIdle: begin
          if (start_i) state_q <= StArmed;
        end
        StArmed: begin
          pc_q <= table_q[0];
          if (!start_i) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (start_i) begin
            // Abort: PC is reloaded from the table by the armed state.
            state_q   <= StArmed;
            running_q <= 1'b0;
          end else if (pc_q == HaltPc) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (stall_i) begin
            // Hold; a stalled taken branch is dropped and re-presented by the decoder.
          end
`ifdef PC_SEQ_LINK_EN
          else if (ret_i) begin
            pc_q <= link_q;
          end
`endif
          else if (branch_en_i && taken_i) begin
            pc_q <= table_q[target_sel_i];
`ifdef PC_SEQ_LINK_EN
            if (link_i) link_q <= pc_q + 1'b1;
`endif
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        StDone: begin
          if (start_i) begin
            state_q <= StArmed;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign prog_ctr_o = pc_q;
  assign running_o  = running_q;
  assign done_o     = done_q;
  assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each cycle's stimulus pushes the expected
// registered outputs, which are popped and compared one cycle later.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_en, taken, cfg_we;
  logic [2:0] target_sel, cfg_addr;
  logic [9:0] cfg_data;
  logic       link, ret;
  logic [9:0] prog_ctr;
  logic       running, done, cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst, start, stall, br, tk;
    logic [2:0] sel;
    logic       we;
    logic [2:0] addr;
    logic [9:0] data;
    logic       lk, rt;
  } stim_t;

  typedef struct packed {
    logic [9:0] pc;
    logic       run, done, err;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(
    .PC_W     (10),
    .SEL_W    (3),
    .HALT_ADDR(1023)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .stall_i     (stall),
    .branch_en_i (branch_en),
    .taken_i     (taken),
    .target_sel_i(target_sel),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
`ifdef PC_SEQ_LINK_EN
    .link_i      (link),
    .ret_i       (ret),
`endif
    .prog_ctr_o  (prog_ctr),
    .running_o   (running),
    .done_o      (done),
    .cfg_err_o   (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(logic rst, logic st, logic sl, logic br, logic tk, logic [2:0] sel,
                              logic we, logic [2:0] a, logic [9:0] d, logic lk, logic rt);
    return '{rst: rst, start: st, stall: sl, br: br, tk: tk, sel: sel, we: we, addr: a,
             data: d, lk: lk, rt: rt};
  endfunction

  function automatic exp_t E(logic [9:0] pc, logic run, logic dn, logic err);
    return '{pc: pc, run: run, done: dn, err: err};
  endfunction

  // Drive one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic apply(input stim_t s);
    reset = s.rst; start = s.start; stall = s.stall; branch_en = s.br; taken = s.tk;
    target_sel = s.sel; cfg_we = s.we; cfg_addr = s.addr; cfg_data = s.data;
    link = s.lk; ret = s.rt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0));
    for (int i = 0; i < 3; i++) begin
      st.push_back(S(0,1,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,0,0,0));
    end
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,0,0));
    for (int i = 1; i <= 3; i++) begin
      st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(10'(i),1,0,0));
    end
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(4,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(5,1,0,0));
    st.push_back(S(0,0,0,1,1,3,0,0,0,0,0)); ex.push_back(E(63,1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0,0,0,0)); ex.push_back(E(63,0,0,0)); // abort holds PC
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(0,1,0,0));
    for (int i = 1; i <= 5; i++) begin
      st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(10'(i),1,0,0));
    end
    st.push_back(S(0,0,0,1,0,3,0,0,0,0,0)); ex.push_back(E(6,1,0,0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL branch cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    for (int i = 7; i <= 10; i++) begin
      st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(10'(i),1,0,0));
    end
    st.push_back(S(0,0,1,1,1,5,0,0,0,0,0)); ex.push_back(E(10,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(11,1,0,0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL stall cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask

  task automatic test_halt();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(0,0,0,1,1,7,0,0,0,0,0));   ex.push_back(E(1023,1,0,0));
    st.push_back(S(0,0,0,1,1,3,0,0,0,0,0));   ex.push_back(E(1023,0,1,0)); // halt beats branch
    st.push_back(S(0,0,0,0,0,0,1,2,300,0,0)); ex.push_back(E(1023,0,1,0)); // write in DONE ok
    st.push_back(S(0,1,0,0,0,0,0,0,0,0,0));   ex.push_back(E(1023,0,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0,0,0,0));   ex.push_back(E(0,0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(0,1,0,0));
    st.push_back(S(0,0,0,1,1,2,0,0,0,0,0));   ex.push_back(E(300,1,0,0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL halt cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask

  task automatic test_cfg();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(0,0,0,0));
    st.push_back(S(0,1,0,0,0,0,1,0,100,0,0)); ex.push_back(E(0,0,0,0));   // write with Start
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(100,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(101,1,0,0));
    st.push_back(S(0,0,0,0,0,0,1,0,7,0,0));   ex.push_back(E(102,1,0,1));  // refused in RUN
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(103,1,0,0));
    st.push_back(S(0,1,0,0,0,0,1,1,9,0,0));   ex.push_back(E(103,0,0,1));
    st.push_back(S(0,1,0,0,0,0,1,0,9,0,0));   ex.push_back(E(100,0,0,1));  // refused in ARMED
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(100,1,0,0));
    st.push_back(S(0,0,0,1,1,1,0,0,0,0,0));   ex.push_back(E(36,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));   ex.push_back(E(37,1,0,0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL cfg cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(0,0,0,1,1,4,0,0,0,0,0)); ex.push_back(E(68,1,0,0));
    st.push_back(S(0,0,0,1,1,5,0,0,0,0,0)); ex.push_back(E(208,1,0,0));
    st.push_back(S(0,0,0,1,1,3,0,0,0,0,0)); ex.push_back(E(63,1,0,0));
    st.push_back(S(0,0,0,1,0,3,0,0,0,0,0)); ex.push_back(E(64,1,0,0));
    st.push_back(S(0,0,1,0,0,0,0,0,0,0,0)); ex.push_back(E(64,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0)); ex.push_back(E(65,1,0,0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL b2b cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask

`ifdef PC_SEQ_LINK_EN
  task automatic test_link();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  e;
    st.push_back(S(1,0,0,0,0,0,0,0,0,0,0));  ex.push_back(E(0,0,0,0));
    st.push_back(S(0,1,0,0,0,0,1,0,20,0,0)); ex.push_back(E(0,0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));  ex.push_back(E(20,1,0,0));
    st.push_back(S(0,0,0,1,1,4,0,0,0,1,0));  ex.push_back(E(68,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));  ex.push_back(E(69,1,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,1));  ex.push_back(E(21,1,0,0));
    st.push_back(S(0,0,0,1,1,5,0,0,0,0,1));  ex.push_back(E(21,1,0,0)); // Ret beats branch
    st.push_back(S(0,0,0,0,0,0,0,0,0,0,0));  ex.push_back(E(22,1,0,0));
    foreach (st[i]) begin
      sb.push_back(ex[i]);
      apply(st[i]);
      e = sb.pop_front();
      checks++;
      if ({prog_ctr, running, done, cfg_err} !== e) begin
        errors++;
        $display("FAIL link cyc %0d: got pc=%0d run=%b done=%b err=%b want pc=%0d run=%b done=%b err=%b",
                 i, prog_ctr, running, done, cfg_err, e.pc, e.run, e.done, e.err);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0; taken = 1'b0;
    target_sel = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; link = 1'b0; ret = 1'b0;
    #2;
    test_reset();
    test_branch();
    test_stall();
    test_halt();
    test_cfg();
    test_back_to_back();
`ifdef PC_SEQ_LINK_EN
    test_link();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
